// File: rtl/seq_divider.sv
// seq_divider: multi-cycle unsigned restoring divider.
// Produces one quotient bit per clock with a start/busy/done handshake.
// Results and the divide-by-zero flag are registered and held until the next done.
module seq_divider #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CW = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  logic [1:0]       state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] dvsr;
  // Partial remainder kept at WIDTH bits: after every restoring step it is
  // strictly below the divisor, so the extra top bit of R is always zero.
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] q_q;

  logic [WIDTH:0]   r_shift;
  logic             ge;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] r_next;
  logic [WIDTH-1:0] q_next;
  logic             accept;

  // One restoring shift/subtract step on the current partial remainder.
  always_comb begin
    r_shift = {r_q, q_q[WIDTH-1]};
    ge      = (r_shift >= {1'b0, dvsr});
    diff    = r_shift[WIDTH-1:0] - dvsr;
    r_next  = ge ? diff : r_shift[WIDTH-1:0];
    q_next  = {q_q[WIDTH-2:0], ge};
  end

  assign accept = start && (state != S_CALC);

  // Handshake outputs decoded straight from the state register.
  assign busy = (state == S_CALC);
  assign done = (state == S_DONE);

  // Control FSM, iteration datapath and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      count       <= '0;
      dvsr        <= '0;
      r_q         <= '0;
      q_q         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        S_CALC: begin
          r_q   <= r_next;
          q_q   <= q_next;
          count <= count - CW'(1);
          if (count == '0) begin
            state       <= S_DONE;
            quotient    <= q_next;
            remainder   <= r_next;
            div_by_zero <= 1'b0;
          end
        end
        default: begin
          // IDLE and DONE behave identically: accept a new start or idle.
          if (accept) begin
            dvsr  <= divisor;
            r_q   <= '0;
            q_q   <= dividend;
            count <= LAST_CNT;
            if (divisor == '0) begin
              state       <= S_DONE;
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else begin
              state <= S_CALC;
            end
          end else begin
            state <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: table-driven exhaustive sweep plus hand-written corner
// sequences; expected results go into a scoreboard queue when driven and
// are compared when done pulses.
module tb_seq_divider;

  localparam int unsigned W   = 4;
  localparam int unsigned LAT = W + 1;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  seq_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
  } vec_t;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    int unsigned  due;
  } exp_t;

  vec_t        tbl [256];
  exp_t        sb [$];
  int unsigned cyc;
  int unsigned n_checks;
  int unsigned n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1);
  end

  // Scoreboard checker: every done pulse must match the oldest pending entry.
  always @(negedge clk) begin
    if (rst_n && done) begin
      exp_t e;
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_done: got done=1 q=%0d r=%0d dbz=%0b at cycle %0d, required no done",
                 quotient, remainder, div_by_zero, cyc);
      end else begin
        e = sb.pop_front();
        if (busy !== 1'b0 || quotient !== e.q || remainder !== e.r ||
            div_by_zero !== e.dbz || cyc != e.due) begin
          n_fail++;
          $display("FAIL result: got busy=%0b q=%0d r=%0d dbz=%0b cycle=%0d, required busy=0 q=%0d r=%0d dbz=%0b cycle=%0d",
                   busy, quotient, remainder, div_by_zero, cyc, e.q, e.r, e.dbz, e.due);
        end
      end
    end
  end

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] req);
    n_checks++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, req);
    end
  endtask

  task automatic push(input logic [W-1:0] q, input logic [W-1:0] r, input logic dbz,
                      input int unsigned lat);
    exp_t e;
    e.q   = q;
    e.r   = r;
    e.dbz = dbz;
    e.due = cyc + lat;
    sb.push_back(e);
  endtask

  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] q, input logic [W-1:0] r, input logic dbz);
    @(negedge clk);
    drive(a, b);
    push(q, r, dbz, (b == '0) ? 1 : LAT);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain(input string name);
    int unsigned k;
    k = 0;
    while (sb.size() != 0 && k < 20) begin
      @(posedge clk);
      k++;
    end
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: got %0d pending results after 20 cycles, required 0", name, sb.size());
      sb.delete();
    end
  endtask

  initial begin
    int unsigned busy_cnt;
    logic        saw_done;

    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;

    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        tbl[a*16+b].a   = W'(a);
        tbl[a*16+b].b   = W'(b);
        tbl[a*16+b].q   = (b == 0) ? 4'd15 : W'(a / b);
        tbl[a*16+b].r   = (b == 0) ? W'(a) : W'(a % b);
        tbl[a*16+b].dbz = (b == 0);
      end
    end

    // Reset state.
    repeat (3) @(negedge clk);
    check("reset_outputs", {5'd0, busy, done, quotient, remainder, div_by_zero}, 16'h0000);
    rst_n = 1'b1;
    @(negedge clk);

    // 13/3: busy for exactly W cycles, done W+1 cycles after start, result held.
    drive(4'd13, 4'd3);
    push(4'd4, 4'd1, 1'b0, LAT);
    busy_cnt = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (k == 0) start = 1'b0;
      if (done) break;
      if (busy) busy_cnt++;
    end
    check("busy_cycles", 16'(busy_cnt), 16'(W));
    drain("first_op");
    repeat (3) @(negedge clk);
    check("result_held", {6'd0, done, quotient, remainder, div_by_zero}, {6'd0, 1'b0, 4'd4, 4'd1, 1'b0});

    // Exhaustive table sweep.
    for (int i = 0; i < 256; i++) begin
      run_op(tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r, tbl[i].dbz);
      drain("sweep");
    end

    // 3/9 then 15/1: first result must hold until the second done.
    run_op(4'd3, 4'd9, 4'd0, 4'd3, 1'b0);
    drain("hold_first");
    @(negedge clk);
    drive(4'd15, 4'd1);
    push(4'd15, 4'd0, 1'b0, LAT);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (k == 0) start = 1'b0;
      if (done) break;
      check("hold_prev_result", {8'd0, quotient, remainder}, {8'd0, 4'd0, 4'd3});
    end
    drain("hold_second");

    // Start pulses during CALC are ignored.
    @(negedge clk);
    drive(4'd13, 4'd3);
    push(4'd4, 4'd1, 1'b0, LAT);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    drive(4'd8, 4'd2);
    @(negedge clk);
    @(negedge clk);
    start = 1'b0;
    drain("ignore_start");
    repeat (6) @(negedge clk);

    // Asynchronous reset mid-operation aborts without a done.
    run_op(4'd13, 4'd3, 4'd4, 4'd1, 1'b0);
    drain("pre_reset");
    @(negedge clk);
    drive(4'd14, 4'd5);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("async_reset_outputs", {5'd0, busy, done, quotient, remainder, div_by_zero}, 16'h0000);
    saw_done = 1'b0;
    repeat (3) begin
      @(negedge clk);
      saw_done = saw_done | done;
    end
    check("no_done_in_reset", {15'd0, saw_done}, 16'h0000);
    rst_n = 1'b1;
    run_op(4'd14, 4'd5, 4'd2, 4'd4, 1'b0);
    drain("after_reset");

    // Back-to-back with start held: 9/2 then 10/3 accepted in the DONE cycle.
    @(negedge clk);
    drive(4'd9, 4'd2);
    push(4'd4, 4'd1, 1'b0, LAT);
    saw_done = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done) begin
        saw_done = 1'b1;
        drive(4'd10, 4'd3);
        push(4'd3, 4'd1, 1'b0, LAT);
        break;
      end
    end
    check("b2b_first_done", {15'd0, saw_done}, 16'h0001);
    @(negedge clk);
    start = 1'b0;
    drain("back_to_back");
    repeat (8) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
